// File: rtl/tdm_demux.sv
// Receive side of the TDM link: demultiplexes a serial slot stream into one parallel frame.
// Optional TDM_PARITY_EN adds a trailing even-parity slot per frame and a par_err pulse.
module tdm_demux #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned DW   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DW-1:0]     in_data,
  input  logic              in_sof,
  output logic [N_CH*DW-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sync_err,
  input  logic              ovf_clr,
  output logic              overflow
`ifdef TDM_PARITY_EN
  ,
  output logic              par_err
`endif
);

  localparam int unsigned IW = $clog2(N_CH + 1);
`ifdef TDM_PARITY_EN
  localparam int unsigned LAST = N_CH;
`else
  localparam int unsigned LAST = N_CH - 1;
`endif

  typedef enum logic {StHunt, StCollect} state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [N_CH*DW-1:0]  asm_q, asm_d;
  logic [N_CH*DW-1:0]  out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                sync_err_q, sync_err_d;
  logic                overflow_q, overflow_d;
  logic                par_err_q, par_err_d;
  logic                complete;
  logic                frame_ok;
  logic [DW-1:0]       par_calc;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    asm_d       = asm_q;
    sync_err_d  = 1'b0;
    par_err_d   = 1'b0;
    complete    = 1'b0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overflow_d  = overflow_q;
    par_calc    = '0;

    if (in_valid) begin
      unique case (state_q)
        StHunt: begin
          if (in_sof) begin
            asm_d            = '0;
            asm_d[DW-1:0]    = in_data;
            idx_d            = IW'(1);
            state_d          = StCollect;
          end
        end
        StCollect: begin
          if (in_sof && idx_q != '0) begin
            // Resync on the unexpected sof: drop the partial frame, keep this beat as slot 0.
            sync_err_d    = 1'b1;
            asm_d         = '0;
            asm_d[DW-1:0] = in_data;
            idx_d         = IW'(1);
          end else if (!in_sof && idx_q == '0) begin
            sync_err_d = 1'b1;
            state_d    = StHunt;
          end else begin
            for (int k = 0; k < N_CH; k++) begin
              if (idx_q == IW'(k)) asm_d[k*DW +: DW] = in_data;
            end
            if (idx_q == IW'(LAST)) begin
              idx_d    = '0;
              complete = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end

    for (int k = 0; k < N_CH; k++) par_calc = par_calc ^ asm_q[k*DW +: DW];
`ifdef TDM_PARITY_EN
    frame_ok = (par_calc == in_data);
    if (complete && !frame_ok) par_err_d = 1'b1;
`else
    frame_ok = 1'b1;
`endif

    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (ovf_clr) overflow_d = 1'b0;
    if (complete && frame_ok) begin
      if (!out_valid_q || out_ready) begin
        out_data_d  = asm_d;
        out_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StHunt;
      idx_q       <= '0;
      asm_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      overflow_q  <= 1'b0;
      par_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sync_err_q  <= sync_err_d;
      overflow_q  <= overflow_d;
      par_err_q   <= par_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign sync_err  = sync_err_q;
  assign overflow  = overflow_q;
`ifdef TDM_PARITY_EN
  assign par_err   = par_err_q;
`else
  logic unused_par;
  assign unused_par = ^{par_err_q, par_err_d, par_calc};
`endif

endmodule
